// File: rtl/motor_cmd_scheduler.sv
// rtl/motor_cmd_scheduler.sv - priority arbiter and frame sequencer feeding the wheel-speed JSON formatter
module motor_cmd_scheduler #(
    parameter int N_REQ        = 3,
    parameter int HB_CLKS      = 5_000_000,
    parameter int GAP_CLKS     = 1_000,
    parameter int TIMEOUT_CLKS = 50_000,
    parameter int MAG_MAX      = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_REQ-1:0]     req,
    input  logic [N_REQ-1:0]     req_neg_l,
    input  logic [N_REQ-1:0]     req_neg_r,
    input  logic [4*N_REQ-1:0]   req_mag_l,
    input  logic [4*N_REQ-1:0]   req_mag_r,
    output logic [N_REQ-1:0]     grant,
    output logic                 fmt_start,
    output logic                 fmt_neg_l,
    output logic                 fmt_neg_r,
    output logic [3:0]           fmt_mag_l,
    output logic [3:0]           fmt_mag_r,
    input  logic                 fmt_done,
    output logic [1:0]           active_src,
    output logic                 hb_active,
    output logic                 timeout_err
);

    localparam int HB_W  = $clog2(HB_CLKS + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CLKS + 1);
    localparam int GAP_W = $clog2(GAP_CLKS + 1);

    localparam logic [HB_W-1:0]  HB_MAX   = HB_W'(HB_CLKS);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CLKS - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CLKS - 1);
    localparam logic [3:0]       MAG_LIM  = 4'(MAG_MAX);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_GAP   = 2'd3
    } state_t;

    typedef struct packed {
        logic       neg_l;
        logic       neg_r;
        logic [3:0] mag_l;
        logic [3:0] mag_r;
    } cmd_t;

    state_t           state;
    cmd_t             fmt_cmd;
    cmd_t             last_cmd;
    logic             last_valid;
    logic [HB_W-1:0]  hb_cnt;
    logic [TO_W-1:0]  wait_cnt;
    logic [GAP_W-1:0] gap_cnt;

    logic             sel_any;
    logic [1:0]       sel_idx;
    logic [N_REQ-1:0] sel_onehot;
    logic             sel_neg_l;
    logic             sel_neg_r;
    logic [3:0]       sel_raw_l;
    logic [3:0]       sel_raw_r;
    logic [3:0]       sel_mag_l;
    logic [3:0]       sel_mag_r;
    cmd_t             sel_cmd;
    logic             hb_due;
    logic             dup;

    // Scan from the top so the lowest set index is the one left standing.
    always_comb begin
        sel_any   = 1'b0;
        sel_idx   = 2'd0;
        sel_neg_l = 1'b0;
        sel_neg_r = 1'b0;
        sel_raw_l = 4'd0;
        sel_raw_r = 4'd0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                sel_any   = 1'b1;
                sel_idx   = 2'(i);
                sel_neg_l = req_neg_l[i];
                sel_neg_r = req_neg_r[i];
                sel_raw_l = req_mag_l[4*i +: 4];
                sel_raw_r = req_mag_r[4*i +: 4];
            end
        end
    end

    always_comb begin
        sel_onehot = '0;
        for (int i = 0; i < N_REQ; i++) begin
            sel_onehot[i] = sel_any && (sel_idx == 2'(i));
        end
    end

    // A zero magnitude never carries a reverse flag, so "-0.0" is never emitted.
    always_comb begin
        sel_mag_l     = (sel_raw_l > MAG_LIM) ? MAG_LIM : sel_raw_l;
        sel_mag_r     = (sel_raw_r > MAG_LIM) ? MAG_LIM : sel_raw_r;
        sel_cmd.mag_l = sel_mag_l;
        sel_cmd.mag_r = sel_mag_r;
        sel_cmd.neg_l = sel_neg_l && (sel_mag_l != 4'd0);
        sel_cmd.neg_r = sel_neg_r && (sel_mag_r != 4'd0);
    end

    assign hb_due = last_valid && (hb_cnt >= HB_MAX);
    assign dup    = last_valid && (sel_cmd == last_cmd) && !hb_due;

    assign fmt_neg_l = fmt_cmd.neg_l;
    assign fmt_neg_r = fmt_cmd.neg_r;
    assign fmt_mag_l = fmt_cmd.mag_l;
    assign fmt_mag_r = fmt_cmd.mag_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            fmt_cmd     <= '0;
            last_cmd    <= '0;
            last_valid  <= 1'b0;
            hb_cnt      <= '0;
            wait_cnt    <= '0;
            gap_cnt     <= '0;
            grant       <= '0;
            fmt_start   <= 1'b0;
            active_src  <= 2'd0;
            hb_active   <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            grant     <= '0;
            fmt_start <= 1'b0;
            if (state != S_START && hb_cnt != HB_MAX) begin
                hb_cnt <= hb_cnt + 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (sel_any) begin
                        grant <= sel_onehot;
                        if (!dup) begin
                            fmt_cmd    <= sel_cmd;
                            active_src <= sel_idx;
                            hb_active  <= 1'b0;
                            state      <= S_START;
                        end
                    end else if (hb_due) begin
                        fmt_cmd   <= last_cmd;
                        hb_active <= 1'b1;
                        state     <= S_START;
                    end
                end
                S_START: begin
                    fmt_start  <= 1'b1;
                    last_cmd   <= fmt_cmd;
                    last_valid <= 1'b1;
                    hb_cnt     <= '0;
                    wait_cnt   <= '0;
                    state      <= S_WAIT;
                end
                S_WAIT: begin
                    // A done arriving on the final allowed cycle still counts as a clean finish.
                    if (fmt_done) begin
                        gap_cnt <= '0;
                        state   <= S_GAP;
                    end else if (wait_cnt == TO_LAST) begin
                        timeout_err <= 1'b1;
                        gap_cnt     <= '0;
                        state       <= S_GAP;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state <= S_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_motor_cmd_scheduler.sv
// tb/tb_motor_cmd_scheduler.sv - self-checking bench for motor_cmd_scheduler
module tb_motor_cmd_scheduler;

    localparam int N_REQ = 3;
    localparam int HB    = 200;
    localparam int GAP   = 4;
    localparam int TO    = 50;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [N_REQ-1:0]     req = '0;
    logic [N_REQ-1:0]     req_neg_l = '0;
    logic [N_REQ-1:0]     req_neg_r = '0;
    logic [4*N_REQ-1:0]   req_mag_l = '0;
    logic [4*N_REQ-1:0]   req_mag_r = '0;
    logic [N_REQ-1:0]     grant;
    logic                 fmt_start;
    logic                 fmt_neg_l;
    logic                 fmt_neg_r;
    logic [3:0]           fmt_mag_l;
    logic [3:0]           fmt_mag_r;
    logic                 fmt_done = 1'b0;
    logic [1:0]           active_src;
    logic                 hb_active;
    logic                 timeout_err;

    motor_cmd_scheduler #(
        .N_REQ(N_REQ), .HB_CLKS(HB), .GAP_CLKS(GAP), .TIMEOUT_CLKS(TO), .MAG_MAX(10)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_neg_l(req_neg_l), .req_neg_r(req_neg_r),
        .req_mag_l(req_mag_l), .req_mag_r(req_mag_r), .grant(grant), .fmt_start(fmt_start),
        .fmt_neg_l(fmt_neg_l), .fmt_neg_r(fmt_neg_r), .fmt_mag_l(fmt_mag_l), .fmt_mag_r(fmt_mag_r),
        .fmt_done(fmt_done), .active_src(active_src), .hb_active(hb_active), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       nl;
        logic       nr;
        logic [3:0] ml;
        logic [3:0] mr;
        logic [1:0] src;
        logic       hb;
    } frame_t;

    frame_t exp_q[$];
    int     checks = 0;
    int     errors = 0;
    int     start_seen = 0;
    bit     auto_done = 1'b1;
    int     done_cnt = 0;

    function automatic frame_t mk(input logic nl, input logic nr, input logic [3:0] ml,
                                  input logic [3:0] mr, input logic [1:0] src, input logic hb);
        frame_t f;
        f.nl = nl; f.nr = nr; f.ml = ml; f.mr = mr; f.src = src; f.hb = hb;
        return f;
    endfunction

    // Formatter model: completes a frame three cycles after fmt_start when enabled.
    always @(posedge clk) begin
        #2;
        fmt_done = 1'b0;
        if (done_cnt != 0) begin
            done_cnt--;
            if (done_cnt == 0) fmt_done = 1'b1;
        end
        if (fmt_start && auto_done) done_cnt = 3;
    end

    always @(negedge clk) begin
        if (rst_n && fmt_start) begin
            frame_t got;
            frame_t e;
            start_seen++;
            got = mk(fmt_neg_l, fmt_neg_r, fmt_mag_l, fmt_mag_r, active_src, hb_active);
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_fmt_start: got %h, no frame expected", got);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin
                    errors++;
                    $display("FAIL frame: got nl=%0b nr=%0b ml=%0d mr=%0d src=%0d hb=%0b, expected nl=%0b nr=%0b ml=%0d mr=%0d src=%0d hb=%0b",
                             got.nl, got.nr, got.ml, got.mr, got.src, got.hb,
                             e.nl, e.nr, e.ml, e.mr, e.src, e.hb);
                end
            end
        end
    end

    task automatic set_src(input int i, input logic nl, input logic nr,
                           input logic [3:0] ml, input logic [3:0] mr);
        req_neg_l[i] = nl;
        req_neg_r[i] = nr;
        req_mag_l[4*i +: 4] = ml;
        req_mag_r[4*i +: 4] = mr;
    endtask

    task automatic wait_grant(input logic [N_REQ-1:0] mask, input int limit, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((grant & mask) == '0 && n < limit);
        if ((grant & mask) == '0) n = -1;
    endtask

    task automatic wait_start(input int limit, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!fmt_start && n < limit);
        if (!fmt_start) n = -1;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({grant, fmt_start, fmt_neg_l, fmt_neg_r, fmt_mag_l, fmt_mag_r, active_src, hb_active, timeout_err} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got grant=%b start=%b mag=%0d/%0d src=%0d hb=%b to=%b, expected all 0",
                     grant, fmt_start, fmt_mag_l, fmt_mag_r, active_src, hb_active, timeout_err);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_priority_latency();
        int n;
        set_src(1, 1'b0, 1'b0, 4'd10, 4'd10);
        set_src(2, 1'b0, 1'b0, 4'd0, 4'd0);
        exp_q.push_back(mk(1'b0, 1'b0, 4'd10, 4'd10, 2'd1, 1'b0));
        exp_q.push_back(mk(1'b0, 1'b0, 4'd0, 4'd0, 2'd2, 1'b0));
        req = 3'b110;
        @(negedge clk);
        checks++;
        if (grant !== 3'b010) begin
            errors++;
            $display("FAIL grant_k1: got %b, expected 010", grant);
        end
        req = 3'b100;
        @(negedge clk);
        checks++;
        if (fmt_start !== 1'b1 || active_src !== 2'd1) begin
            errors++;
            $display("FAIL start_k2: got start=%b src=%0d, expected start=1 src=1", fmt_start, active_src);
        end
        n = 0;
        while (fmt_done !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (fmt_done !== 1'b1) begin
            errors++;
            $display("FAIL done_seen: got fmt_done=%b, expected 1 within 20 clocks", fmt_done);
        end
        wait_grant(3'b100, 20, n);
        checks++;
        if (n != 6) begin
            errors++;
            $display("FAIL gap_to_grant: got %0d clocks after done, expected 6", n);
        end
        req = 3'b000;
        wait_start(5, n);
        checks++;
        if (n != 1) begin
            errors++;
            $display("FAIL src2_start: got %0d clocks after grant, expected 1", n);
        end
        repeat (12) @(negedge clk);
    endtask

    task automatic test_clamp_order();
        int n;
        set_src(0, 1'b1, 1'b1, 4'd15, 4'd0);
        set_src(2, 1'b0, 1'b1, 4'd3, 4'd7);
        exp_q.push_back(mk(1'b1, 1'b0, 4'd10, 4'd0, 2'd0, 1'b0));
        exp_q.push_back(mk(1'b0, 1'b1, 4'd3, 4'd7, 2'd2, 1'b0));
        req = 3'b101;
        @(negedge clk);
        checks++;
        if (grant !== 3'b001) begin
            errors++;
            $display("FAIL prio_grant: got %b, expected 001", grant);
        end
        req = 3'b100;
        @(negedge clk);
        checks++;
        if (fmt_start !== 1'b1 || fmt_mag_l !== 4'd10 || fmt_neg_l !== 1'b1 || fmt_neg_r !== 1'b0) begin
            errors++;
            $display("FAIL clamp: got start=%b mag_l=%0d neg_l=%b neg_r=%b, expected 1 10 1 0",
                     fmt_start, fmt_mag_l, fmt_neg_l, fmt_neg_r);
        end
        wait_grant(3'b100, 30, n);
        checks++;
        if (n < 0) begin
            errors++;
            $display("FAIL pending_grant: got no grant[2], expected grant within 30 clocks");
        end
        req = 3'b000;
        wait_start(5, n);
        repeat (12) @(negedge clk);
    endtask

    task automatic test_dup_heartbeat();
        int n;
        int s;
        req = 3'b100;
        @(negedge clk);
        checks++;
        if (grant !== 3'b100) begin
            errors++;
            $display("FAIL dup_grant: got %b, expected 100", grant);
        end
        req = 3'b000;
        s = start_seen;
        repeat (10) @(negedge clk);
        checks++;
        if (start_seen != s) begin
            errors++;
            $display("FAIL dup_suppress: got %0d frames, expected 0", start_seen - s);
        end
        exp_q.push_back(mk(1'b0, 1'b1, 4'd3, 4'd7, 2'd2, 1'b1));
        wait_start(260, n);
        checks++;
        if (n < 170 || n > 190 || hb_active !== 1'b1) begin
            errors++;
            $display("FAIL heartbeat: got after %0d clocks hb=%b, expected 170..190 hb=1", n, hb_active);
        end
        repeat (12) @(negedge clk);
    endtask

    task automatic test_timeout();
        int n;
        auto_done = 1'b0;
        set_src(1, 1'b1, 1'b0, 4'd5, 4'd5);
        exp_q.push_back(mk(1'b1, 1'b0, 4'd5, 4'd5, 2'd1, 1'b0));
        req = 3'b010;
        wait_grant(3'b010, 5, n);
        req = 3'b000;
        wait_start(5, n);
        n = 0;
        while (timeout_err !== 1'b1 && n < 80) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n != TO) begin
            errors++;
            $display("FAIL timeout_delay: got %0d clocks, expected %0d", n, TO);
        end
        checks++;
        if (fmt_mag_l !== 4'd5 || fmt_neg_l !== 1'b1) begin
            errors++;
            $display("FAIL fields_held: got mag_l=%0d neg_l=%b, expected 5 1", fmt_mag_l, fmt_neg_l);
        end
        repeat (8) @(negedge clk);
        auto_done = 1'b1;
        set_src(0, 1'b0, 1'b0, 4'd2, 4'd4);
        exp_q.push_back(mk(1'b0, 1'b0, 4'd2, 4'd4, 2'd0, 1'b0));
        req = 3'b001;
        wait_grant(3'b001, 5, n);
        checks++;
        if (n != 1) begin
            errors++;
            $display("FAIL after_timeout_grant: got %0d clocks, expected 1", n);
        end
        req = 3'b000;
        wait_start(5, n);
        checks++;
        if (timeout_err !== 1'b1) begin
            errors++;
            $display("FAIL timeout_sticky: got %b, expected 1", timeout_err);
        end
        repeat (12) @(negedge clk);
    endtask

    task automatic test_reset_mid_frame();
        int n;
        int s;
        auto_done = 1'b0;
        set_src(1, 1'b0, 1'b0, 4'd7, 4'd7);
        exp_q.push_back(mk(1'b0, 1'b0, 4'd7, 4'd7, 2'd1, 1'b0));
        req = 3'b010;
        wait_grant(3'b010, 5, n);
        req = 3'b000;
        wait_start(5, n);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({grant, fmt_start, fmt_neg_l, fmt_neg_r, fmt_mag_l, fmt_mag_r, active_src, hb_active, timeout_err} !== '0) begin
            errors++;
            $display("FAIL async_reset: got mag=%0d/%0d src=%0d hb=%b to=%b, expected all 0",
                     fmt_mag_l, fmt_mag_r, active_src, hb_active, timeout_err);
        end
        @(negedge clk);
        rst_n = 1'b1;
        auto_done = 1'b1;
        s = start_seen;
        repeat (230) @(negedge clk);
        checks++;
        if (start_seen != s) begin
            errors++;
            $display("FAIL no_hb_after_reset: got %0d frames, expected 0", start_seen - s);
        end
    endtask

    task automatic test_req_vs_heartbeat();
        int n;
        set_src(1, 1'b0, 1'b0, 4'd1, 4'd2);
        exp_q.push_back(mk(1'b0, 1'b0, 4'd1, 4'd2, 2'd1, 1'b0));
        req = 3'b010;
        wait_grant(3'b010, 5, n);
        req = 3'b000;
        wait_start(5, n);
        repeat (HB) @(negedge clk);
        set_src(0, 1'b1, 1'b1, 4'd4, 4'd9);
        exp_q.push_back(mk(1'b1, 1'b1, 4'd4, 4'd9, 2'd0, 1'b0));
        req = 3'b001;
        @(negedge clk);
        checks++;
        if (grant !== 3'b001) begin
            errors++;
            $display("FAIL req_beats_hb: got grant %b, expected 001", grant);
        end
        req = 3'b000;
        @(negedge clk);
        checks++;
        if (fmt_start !== 1'b1 || hb_active !== 1'b0) begin
            errors++;
            $display("FAIL req_frame: got start=%b hb=%b, expected 1 0", fmt_start, hb_active);
        end
        exp_q.push_back(mk(1'b1, 1'b1, 4'd4, 4'd9, 2'd0, 1'b1));
        wait_start(260, n);
        checks++;
        if (n < 200 || n > 204) begin
            errors++;
            $display("FAIL hb_restart: got next frame after %0d clocks, expected 200..204", n);
        end
        repeat (12) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_priority_latency();
        test_clamp_order();
        test_dup_heartbeat();
        test_timeout();
        test_reset_mid_frame();
        test_req_vs_heartbeat();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL frames_outstanding: got %0d unsent, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion by time limit, expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
